// File: rtl/tick_sched_pkg.sv
// Shared types, widths and helpers for tick_scheduler. No logic, no latency, no flow control.
// Expire counter width is only used when TICK_SCHED_EXPCNT_EN is defined.
package tick_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  localparam int CNT_W     = 16;
  localparam int EXP_CNT_W = 8;

  // A programmed period of zero behaves as a single tick.
  function automatic logic [31:0] eff_period(input logic [31:0] p);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/tick_sched_channel.sv
// One countdown channel: IDLE/RUN FSM, period/mode regs and count; expire registered (1 cycle).
// No backpressure; strobes always taken. TICK_SCHED_EXPCNT_EN adds a saturating expire counter.
module tick_sched_channel #(
  parameter int CNT_W = tick_sched_pkg::CNT_W
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_auto,
  input  logic             start,
  input  logic             stop,
  output logic             running,
  output logic             running_nxt,
  output logic             expire
`ifdef TICK_SCHED_EXPCNT_EN
  ,
  input  logic                                exp_clr,
  output logic [tick_sched_pkg::EXP_CNT_W-1:0] exp_count
`endif
);

  import tick_sched_pkg::*;

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             auto_q, auto_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;
  logic [CNT_W-1:0] reload;

  // Reloads always use the period held before any same-cycle cfg write.
  assign reload = CNT_W'(eff_period(32'(period_q)));

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    auto_d   = auto_q;
    cnt_d    = cnt_q;
    expire_d = 1'b0;

    if (cfg_wr) begin
      period_d = cfg_period;
      auto_d   = cfg_auto;
    end

    case (state_q)
      IDLE: begin
        if (!stop && start) begin
          state_d = RUN;
          cnt_d   = reload;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          cnt_d = reload;
        end else if (tick_in) begin
          if (cnt_q <= CNT_W'(1)) begin
            expire_d = 1'b1;
            if (auto_q) begin
              cnt_d = reload;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      auto_q   <= 1'b0;
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      auto_q   <= auto_d;
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign running     = (state_q == RUN);
  assign running_nxt = (state_d == RUN);
  assign expire      = expire_q;

`ifdef TICK_SCHED_EXPCNT_EN
  logic [EXP_CNT_W-1:0] exp_cnt_q, exp_cnt_d;

  // Counts visible expire pulses; clear wins over a coincident pulse.
  always_comb begin
    exp_cnt_d = exp_cnt_q;
    if (exp_clr) begin
      exp_cnt_d = '0;
    end else if (expire_q && (exp_cnt_q != {EXP_CNT_W{1'b1}})) begin
      exp_cnt_d = exp_cnt_q + EXP_CNT_W'(1);
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      exp_cnt_q <= '0;
    end else begin
      exp_cnt_q <= exp_cnt_d;
    end
  end

  assign exp_count = exp_cnt_q;
`endif

endmodule

// File: rtl/tick_scheduler.sv
// NUM_CH countdown channels sharing one prescaler tick; expire/running 1 cycle after the sampling edge.
// No backpressure. Define TICK_SCHED_EXPCNT_EN for per-channel exp_count/exp_clr.
module tick_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = tick_sched_pkg::CNT_W,
  parameter int CH_W   = 2
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              tick_in,
  output logic              div_enable,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_auto,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] expire
`ifdef TICK_SCHED_EXPCNT_EN
  ,
  output logic [NUM_CH*tick_sched_pkg::EXP_CNT_W-1:0] exp_count,
  input  logic [NUM_CH-1:0]                           exp_clr
`endif
);

  import tick_sched_pkg::*;

  logic [NUM_CH-1:0] running_nxt;
  logic              div_enable_q, div_enable_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_wr;

    // Selects >= NUM_CH never match any channel and are dropped.
    assign ch_wr = cfg_wr && (cfg_ch == CH_W'(i));

    tick_sched_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clkin      (clkin),
      .rst        (rst),
      .tick_in    (tick_in),
      .cfg_wr     (ch_wr),
      .cfg_period (cfg_period),
      .cfg_auto   (cfg_auto),
      .start      (start[i]),
      .stop       (stop[i]),
      .running    (running[i]),
      .running_nxt(running_nxt[i]),
      .expire     (expire[i])
`ifdef TICK_SCHED_EXPCNT_EN
      ,
      .exp_clr    (exp_clr[i]),
      .exp_count  (exp_count[i*EXP_CNT_W +: EXP_CNT_W])
`endif
    );
  end

  // Registered from next-state running so the enable tracks running cycle for cycle.
  assign div_enable_d = |running_nxt;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      div_enable_q <= 1'b0;
    end else begin
      div_enable_q <= div_enable_d;
    end
  end

  assign div_enable = div_enable_q;

endmodule
